ip_frame_assembler: RTL and testbench
=====================================

IP_FRAME_ASSEMBLER -- requirements
Module: ip_frame_assembler

Interface
REQ-001 SHALL have parameter PAYLOAD_LEN, default 262, max TCP payload bytes.
REQ-002 SHALL have parameter TCPH_LEN, default 20, TCP header bytes.
REQ-003 SHALL have parameter IPH_LEN, default 20, IP header bytes; MAXB = PAYLOAD_LEN+TCPH_LEN+IPH_LEN, W = MAXB*8.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port rx_byte  input  8  received IP datagram byte, network order.
REQ-007 SHALL have port rx_valid  input  1  rx_byte/rx_sof/rx_eof qualifier.
REQ-008 SHALL have port rx_sof  input  1  first byte of datagram.
REQ-009 SHALL have port rx_eof  input  1  last byte of datagram.
REQ-010 SHALL have port rx_ip_data  output  W  assembled datagram, left-aligned, zero-padded, registered.
REQ-011 SHALL have port rx_ip_len  output  16  byte count of datagram in rx_ip_data.
REQ-012 SHALL have port rx_ip_valid  output  1  one-cycle pulse, new datagram on rx_ip_data.
REQ-013 SHALL have port rx_ip_err  output  1  one-cycle pulse, datagram discarded.
REQ-014 SHALL have port frame_cnt  output  16  count of rx_ip_valid pulses, saturating at 16'hFFFF.

Function
REQ-015 SHALL implement states IDLE, COLLECT, DROP; inputs sampled only when rx_valid=1.
REQ-016 SHALL place accepted byte k (0-based) at work-buffer bits [W-1-8k -: 8]; work buffer zeroed when a sof byte is accepted.
REQ-017 IDLE: sof byte -> store at k=0, cnt=1, COLLECT; non-sof bytes ignored, no err.
REQ-018 COLLECT: non-sof byte with cnt<MAXB -> store at k=cnt, cnt+1.
REQ-019 COLLECT: byte arriving with cnt==MAXB -> byte discarded, rx_ip_err pulse next cycle, go DROP (or IDLE if that byte has eof).
REQ-020 COLLECT: sof byte -> current datagram discarded, rx_ip_err pulse next cycle, new datagram begun with this byte (cnt=1).
REQ-021 On eof byte accepted in cycle N (same-cycle sof+eof allowed): final cnt evaluated; if cnt<IPH_LEN -> rx_ip_err at N+1; else rx_ip_data<=work buffer, rx_ip_len<=cnt, rx_ip_valid=1 at N+1; state -> IDLE.
REQ-022 DROP: non-sof bytes discarded; eof -> IDLE; sof -> treated as REQ-017.
REQ-023 rx_ip_data and rx_ip_len SHALL hold value between valid pulses; never change without rx_ip_valid.
REQ-024 rx_ip_valid and rx_ip_err SHALL never assert in the same cycle; at most one pulse per cycle.
REQ-025 frame_cnt SHALL increment in the cycle rx_ip_valid asserts.
REQ-026 cnt SHALL be 16 bits and never exceed MAXB.

Reset
REQ-027 rst_n low SHALL asynchronously force IDLE, cnt=0, work buffer=0, rx_ip_data=0, rx_ip_len=0, rx_ip_valid=0, rx_ip_err=0, frame_cnt=0.
REQ-028 Reset mid-datagram SHALL discard partial data with no err pulse; bytes after release ignored until next sof.

Configuration
REQ-029 With IPA_LEN_CHECK_EN defined, at eof the 16-bit total-length field (bytes 2..3) SHALL equal cnt, else rx_ip_err instead of rx_ip_valid.
REQ-030 Without IPA_LEN_CHECK_EN, no total-length comparison SHALL be made; REQ-021 applies unchanged.

Verification
REQ-031 40-byte datagram, bytes 0x45,0x00,0x00,0x28,... contiguous -> rx_ip_valid one cycle after eof, rx_ip_len=40, byte 0 at rx_ip_data[W-1:W-8], low (MAXB-40)*8 bits zero, frame_cnt=1.
REQ-032 MAXB+1 bytes with eof on last -> rx_ip_err once, no rx_ip_valid, rx_ip_data unchanged.
REQ-033 sof at byte 10 of a datagram, then clean 40-byte datagram -> one rx_ip_err, then rx_ip_valid with rx_ip_len=40.
REQ-034 12-byte datagram -> rx_ip_err, no valid; 40-byte datagram with rx_valid gaps -> same result as REQ-031.
REQ-035 rst_n low at byte 20 of a datagram, remaining bytes then a new 40-byte datagram -> no pulse until second datagram's valid, all outputs 0 during reset.
REQ-036 With IPA_LEN_CHECK_EN: 40 bytes, length field 0x0030 -> rx_ip_err; field 0x0028 -> rx_ip_valid.

Source files
------------

// File: rtl/ip_frame_assembler.sv
// ip_frame_assembler: gathers an IP datagram byte stream into a left-aligned, zero-padded buffer.
// Defining IPA_LEN_CHECK_EN also requires the total-length field (bytes 2..3) to match the byte count.
module ip_frame_assembler #(
  parameter int PAYLOAD_LEN = 262,
  parameter int TCPH_LEN = 20,
  parameter int IPH_LEN = 20,
  localparam int MAXB = PAYLOAD_LEN + TCPH_LEN + IPH_LEN,
  localparam int W = MAXB * 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   rx_byte,
  input  logic         rx_valid,
  input  logic         rx_sof,
  input  logic         rx_eof,
  output logic [W-1:0] rx_ip_data,
  output logic [15:0]  rx_ip_len,
  output logic         rx_ip_valid,
  output logic         rx_ip_err,
  output logic [15:0]  frame_cnt
);
  localparam logic [1:0] IDLE = 2'd0, COLLECT = 2'd1, DROP = 2'd2;
  localparam logic [15:0] MAXB16 = 16'(MAXB), IPH16 = 16'(IPH_LEN);
  logic [1:0] state, state_nx;
  logic [15:0] cnt, cnt_nx;
  logic [W-1:0] wbuf, wbuf_nx, byte_top;
  logic drop_err, fin, len_ok, good, bad;
  assign byte_top = {rx_byte, {(W-8){1'b0}}};
  // sof always restarts the buffer; a sof that interrupts an open datagram reports it as dropped
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    wbuf_nx = wbuf;
    drop_err = 1'b0;
    if (rx_valid && rx_sof) begin
      drop_err = state == COLLECT;
      wbuf_nx = byte_top;
      cnt_nx = 16'd1;
      state_nx = COLLECT;
    end else if (rx_valid && state == COLLECT && cnt < MAXB16) begin
      wbuf_nx = wbuf | (byte_top >> {cnt, 3'b000});
      cnt_nx = cnt + 16'd1;
    end else if (rx_valid && state == COLLECT) begin
      drop_err = 1'b1;
      state_nx = DROP;
    end
    fin = rx_valid && rx_eof && state_nx == COLLECT;
    if (rx_valid && rx_eof) state_nx = IDLE;
  end
`ifdef IPA_LEN_CHECK_EN
  assign len_ok = wbuf_nx[W-17 -: 16] == cnt_nx;
`else
  assign len_ok = 1'b1;
`endif
  assign good = fin && cnt_nx >= IPH16 && len_ok && !drop_err;
  assign bad = drop_err || (fin && !good);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      wbuf <= '0;
      rx_ip_data <= '0;
      rx_ip_len <= '0;
      rx_ip_valid <= 1'b0;
      rx_ip_err <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state <= state_nx;
      cnt <= state_nx == IDLE ? 16'd0 : cnt_nx;
      wbuf <= wbuf_nx;
      rx_ip_valid <= good;
      rx_ip_err <= bad;
      if (good) begin
        rx_ip_data <= wbuf_nx;
        rx_ip_len <= cnt_nx;
        frame_cnt <= frame_cnt == 16'hFFFF ? frame_cnt : frame_cnt + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_ip_frame_assembler.sv
// tb_ip_frame_assembler: table-driven datagram vectors with a pulse scoreboard for ip_frame_assembler.
module tb_ip_frame_assembler;
  localparam int MAXB = 302;
  localparam int W = MAXB * 8;
  logic clk = 1'b0, rst_n = 1'b0, rx_valid = 1'b0, rx_sof = 1'b0, rx_eof = 1'b0;
  logic [7:0] rx_byte = '0;
  logic [W-1:0] rx_ip_data;
  logic [15:0] rx_ip_len, frame_cnt;
  logic rx_ip_valid, rx_ip_err;
  ip_frame_assembler dut (
    .clk(clk), .rst_n(rst_n), .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_sof(rx_sof),
    .rx_eof(rx_eof), .rx_ip_data(rx_ip_data), .rx_ip_len(rx_ip_len),
    .rx_ip_valid(rx_ip_valid), .rx_ip_err(rx_ip_err), .frame_cnt(frame_cnt)
  );
  always #5 clk = ~clk;
  typedef struct {int n; logic [15:0] lf; bit g; bit eof; bit e_plain; bit e_chk;} vec_t;
  typedef struct {bit err; int len; logic [W-1:0] data;} exp_t;
  exp_t q[$];
  vec_t tbl[13];
  int n_chk = 0, n_fail = 0, exp_fc = 0;
  bit open = 1'b0;
  logic [W-1:0] prev_d = '0;
  logic [15:0] prev_l = '0;
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask
  task automatic chkd(input logic [W-1:0] a, input logic [W-1:0] e);
    logic [W-1:0] x, y;
    n_chk++;
    if (a !== e) begin
      n_fail++;
      x = a;
      y = e;
      for (int i = 0; i < MAXB; i++) begin
        if (x[W-1 -: 8] !== y[W-1 -: 8]) begin
          $display("FAIL data: byte %0d got %h expected %h", i, x[W-1 -: 8], y[W-1 -: 8]);
          break;
        end
        x = x << 8;
        y = y << 8;
      end
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (rx_ip_valid && rx_ip_err) chk("valid_err_overlap", 32'd1, 32'd0);
      if (!rx_ip_valid) begin
        chk("hold_data", 32'(rx_ip_data == prev_d), 32'd1);
        chk("hold_len", 32'(rx_ip_len), 32'(prev_l));
      end
      if (rx_ip_valid || rx_ip_err) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_pulse: got valid=%0b err=%0b expected none", rx_ip_valid, rx_ip_err);
        end else begin
          e = q.pop_front();
          chk("pulse_kind_err", 32'(rx_ip_err), 32'(e.err));
          if (!e.err) begin
            exp_fc++;
            chk("len", 32'(rx_ip_len), e.len);
            chkd(rx_ip_data, e.data);
          end
          chk("frame_cnt", 32'(frame_cnt), exp_fc);
        end
      end
    end
    prev_d = rx_ip_data;
    prev_l = rx_ip_len;
  end
  task automatic put(input logic [7:0] b, input bit s, input bit f);
    rx_byte = b;
    rx_sof = s;
    rx_eof = f;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_sof = 1'b0;
    rx_eof = 1'b0;
  endtask
  task automatic send(input int n, input logic [15:0] lf, input bit g, input bit eof, input bit ee);
    logic [W-1:0] d = '0;
    logic [7:0] b;
    exp_t e;
    for (int k = 0; k < n; k++) begin
      b = k == 0 ? 8'h45 : k == 1 ? 8'h00 : k == 2 ? lf[15:8] : k == 3 ? lf[7:0] : 8'(k * 3 + n);
      if (k < MAXB) d = {d[W-9:0], b};
      if (k == 0 && open) begin
        e = '{1'b1, 0, '0};
        q.push_back(e);
      end
      if (k == MAXB) begin
        e = '{1'b1, 0, '0};
        q.push_back(e);
      end
      if (eof && k == n - 1 && n <= MAXB) begin
        e = '{ee, n, d << (8 * (MAXB - n))};
        q.push_back(e);
      end
      if (g) repeat ($urandom_range(0, 2)) begin
        rx_byte = 8'($urandom);
        rx_sof = 1'($urandom);
        rx_eof = 1'($urandom);
        @(posedge clk);
        #1;
      end
      rx_sof = 1'b0;
      rx_eof = 1'b0;
      put(b, k == 0, eof && k == n - 1);
    end
    open = !eof && n <= MAXB;
    if (eof) begin
      @(negedge clk);
      #1;
      chk("pulse_latency", q.size(), 32'd0);
    end
  endtask
  task automatic chk_zero();
    chk("rst_valid", 32'(rx_ip_valid), 32'd0);
    chk("rst_err", 32'(rx_ip_err), 32'd0);
    chk("rst_len", 32'(rx_ip_len), 32'd0);
    chk("rst_fcnt", 32'(frame_cnt), 32'd0);
    chk("rst_data_zero", 32'(rx_ip_data == '0), 32'd1);
  endtask
  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    tbl[0]  = '{40, 16'h0028, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{12, 16'h000C, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[2]  = '{40, 16'h0028, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{40, 16'h0030, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[4]  = '{20, 16'h0014, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{19, 16'h0013, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[6]  = '{302, 16'h012E, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{303, 16'h012F, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[8]  = '{10, 16'h0028, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{40, 16'h0028, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[11] = '{310, 16'h0136, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[12] = '{41, 16'h0029, 1'b1, 1'b1, 1'b0, 1'b0};
    repeat (3) @(posedge clk);
    #1;
    chk_zero();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) put(8'(i + 1), 1'b0, i == 3);
    for (int i = 0; i < 13; i++)
`ifdef IPA_LEN_CHECK_EN
      send(tbl[i].n, tbl[i].lf, tbl[i].g, tbl[i].eof, tbl[i].e_chk);
`else
      send(tbl[i].n, tbl[i].lf, tbl[i].g, tbl[i].eof, tbl[i].e_plain);
`endif
    send(20, 16'h0028, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_zero();
    open = 1'b0;
    exp_fc = 0;
    repeat (2) @(negedge clk);
    chk_zero();
    rst_n = 1'b1;
    #1;
    for (int i = 20; i < 40; i++) put(8'(i), 1'b0, i == 39);
    repeat (3) @(negedge clk);
    send(40, 16'h0028, 1'b1, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    chk("queue_empty", q.size(), 32'd0);
    chk("final_fcnt", 32'(frame_cnt), 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
